covariance_axi: RTL and testbench

Accumulates a batch of per-stock return samples into an N_STOCKS×N_STOCKS covariance matrix. It sums the outer product x·xᵀ over N_SAMPLES sample vectors, divides by N_SAMPLES, and then streams the matrix out one entry per cycle. It is the stage directly upstream of the off-diagonal convergence checker. Its output stream is contiguous and uses the same entry order the checker expects: row index i fastest, column index j slow.

---
 rtl/covariance_axi.sv | 131 +++++++++++++
 tb/tb_covariance_axi.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/covariance_axi.sv
// Batch covariance accumulator: sums x*x^T over N_SAMPLES sample vectors, scales
// by 1/N_SAMPLES and streams the N_STOCKS x N_STOCKS matrix one entry per cycle.
module covariance_axi #(
  parameter int WIDTH     = 16,
  parameter int N_STOCKS  = 4,
  parameter int N_SAMPLES = 8,
  parameter int OUT_WIDTH = 16,
  parameter int ACC_WIDTH = 2*WIDTH + $clog2(N_SAMPLES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 axiiv,
  input  logic [WIDTH-1:0]     axiid,
  output logic                 axiir,
  output logic                 axiov,
  output logic [OUT_WIDTH-1:0] axiod,
  output logic                 axiol
);

  localparam int IDX_W = $clog2(N_STOCKS);
  localparam int SHIFT = $clog2(N_SAMPLES);
  localparam int SMP_W = SHIFT + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STOCKS - 1);
  localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'(N_SAMPLES - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_LOAD, S_ACCUM, S_EMIT} state_t;

  state_t                      r_state;
  logic [IDX_W-1:0]            r_k;
  logic [IDX_W-1:0]            r_i;
  logic [IDX_W-1:0]            r_j;
  logic [SMP_W-1:0]            r_smp;
  logic signed [WIDTH-1:0]     r_x   [N_STOCKS];
  logic signed [ACC_WIDTH-1:0] r_acc [N_STOCKS][N_STOCKS];
  logic                        r_axiov;
  logic                        r_axiol;
  logic [OUT_WIDTH-1:0]        r_axiod;

  logic signed [2*WIDTH-1:0]   w_prod;
  logic signed [ACC_WIDTH-1:0] w_sel;
  logic signed [ACC_WIDTH-1:0] w_scaled;
  logic [OUT_WIDTH-1:0]        w_sat;
  logic                        w_last_step;

  // The single shared multiplier always works on the (i, j) pair being visited.
  assign w_prod      = r_x[r_i] * r_x[r_j];
  assign w_sel       = r_acc[r_i][r_j];
  assign w_scaled    = w_sel >>> SHIFT;
  assign w_last_step = (r_i == LAST_IDX) && (r_j == LAST_IDX);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    w_sat = w_scaled[OUT_WIDTH-1:0];
    if (w_scaled > SAT_MAX)      w_sat = SAT_MAX[OUT_WIDTH-1:0];
    else if (w_scaled < SAT_MIN) w_sat = SAT_MIN[OUT_WIDTH-1:0];
  end

  // NOTE: ready is a pure state decode masked by rst, so it is low during the reset cycle.
  assign axiir = (r_state == S_LOAD) && !rst;
  assign axiov = r_axiov;
  assign axiod = r_axiod;
  assign axiol = r_axiol;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_k     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_smp   <= '0;
      r_axiov <= 1'b0;
      r_axiol <= 1'b0;
      r_axiod <= '0;
      // NOTE: the storage arrays are reset on purpose: an aborted batch must leave no residue.
      for (int a = 0; a < N_STOCKS; a++) begin
        r_x[a] <= '0;
        for (int b = 0; b < N_STOCKS; b++) r_acc[a][b] <= '0;
      end
    end else begin
      r_axiov <= 1'b0;
      r_axiol <= 1'b0;
      unique case (r_state)
        S_LOAD: begin
          if (axiiv) begin
            r_x[r_k] <= axiid;
            if (r_k == LAST_IDX) begin
              r_k     <= '0;
              r_state <= S_ACCUM;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        S_ACCUM, S_EMIT: begin
          if (r_state == S_ACCUM) begin
            r_acc[r_i][r_j] <= w_sel + ACC_WIDTH'(w_prod);
          end else begin
            r_acc[r_i][r_j] <= '0;
            r_axiov         <= 1'b1;
            r_axiod         <= w_sat;
            r_axiol         <= w_last_step;
          end
          // Row index i runs fastest, column j slow.
          if (r_i == LAST_IDX) begin
            r_i <= '0;
            r_j <= (r_j == LAST_IDX) ? '0 : r_j + 1'b1;
          end else begin
            r_i <= r_i + 1'b1;
          end
          if (w_last_step) begin
            if (r_state == S_EMIT) begin
              r_smp   <= '0;
              r_state <= S_LOAD;
            end else if (r_smp == LAST_SMP) begin
              r_smp   <= r_smp + 1'b1;
              r_state <= S_EMIT;
            end else begin
              r_smp   <= r_smp + 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_covariance_axi.sv
// Bench for covariance_axi: a batch-level covariance model predicts every output
// cycle and ready level; literal tables pin the model on the directed cases.
module tb_covariance_axi;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int S  = 8;
  localparam int NN = N * N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        axiiv = 1'b0;
  logic [15:0] axiid = '0;
  logic        axiir;
  logic        axiov;
  logic [15:0] axiod;
  logic        axiol;

  covariance_axi #(
    .WIDTH(W), .N_STOCKS(N), .N_SAMPLES(S), .OUT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
    .axiir(axiir), .axiov(axiov), .axiod(axiod), .axiol(axiol)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int     cyc = 0;
  bit     armed = 0;
  bit     post_rst = 0;
  int     ready_at = 0;
  int     stream_start = -1;
  int     streams_done = 0;
  int     emitted = 0;
  int     beat_k = 0;
  int     n_vec = 0;
  longint hist [S][N];
  longint exp_mat [NN];
  logic signed [15:0] slog [32][NN];

  function automatic longint sat_out(input longint v);
    longint sh;
    sh = v >>> $clog2(S);
    if (sh > 32767)  return 32767;
    if (sh < -32768) return -32768;
    return sh;
  endfunction

  task automatic build_expected();
    longint s;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++) begin
        s = 0;
        for (int t = 0; t < S; t++) s += hist[t][i] * hist[t][j];
        exp_mat[j*N + i] = sat_out(s);
      end
  endtask

  // Negedge n observes outputs after posedge n-1 and the handshake for posedge n.
  always @(negedge clk) begin
    bit exp_v;
    int idx;
    cyc++;
    if (armed) begin
      exp_v = (stream_start >= 0) && (cyc >= stream_start) && (cyc < stream_start + NN);
      check("axiov", axiov, exp_v);
      check("axiir", axiir, !rst && (cyc >= ready_at));
      if (exp_v) begin
        idx = cyc - stream_start;
        check($sformatf("axiod[%0d]", idx), $signed(axiod), exp_mat[idx]);
        check("axiol", axiol, idx == NN - 1);
        slog[streams_done % 32][idx] = axiod;
        emitted = idx + 1;
        if (idx == NN - 1) begin
          stream_start = -1;
          streams_done++;
          emitted = 0;
        end
      end else begin
        check("axiol_idle", axiol, 0);
      end
      if (post_rst) begin
        check("axiod_after_rst", $signed(axiod), 0);
        post_rst = 0;
      end
    end
    if (rst) begin
      armed        = 1;
      post_rst     = 1;
      beat_k       = 0;
      n_vec        = 0;
      emitted      = 0;
      stream_start = -1;
      ready_at     = cyc + 1;
    end else if (armed && axiiv && axiir) begin
      hist[n_vec][beat_k] = longint'($signed(axiid));
      beat_k++;
      if (beat_k == N) begin
        beat_k = 0;
        n_vec++;
        if (n_vec == S) begin
          build_expected();
          n_vec        = 0;
          stream_start = cyc + NN + 2;
          ready_at     = cyc + 2*NN + 1;
        end else begin
          ready_at = cyc + NN + 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] d);
    int waited;
    waited = 0;
    axiiv = 1'b1;
    axiid = d;
    @(negedge clk);
    while (!axiir && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!axiir) begin
      n_checks++;
      $display("FAIL accept_timeout: axiir low for %0d cycles, expected 1", waited);
    end
    tick();
  endtask

  task automatic send_vec(input int a0, input int a1, input int a2, input int a3);
    send_beat(16'(a0));
    send_beat(16'(a1));
    send_beat(16'(a2));
    send_beat(16'(a3));
  endtask

  task automatic send_batch(input int a0, input int a1, input int a2, input int a3);
    repeat (S) send_vec(a0, a1, a2, a3);
  endtask

  task automatic idle(input int n);
    axiiv = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_rst();
    axiiv = 1'b0;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
  endtask

  task automatic wait_streams(input int target);
    int n;
    n = 0;
    while (streams_done < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (streams_done < target) begin
      n_checks++;
      $display("FAIL stream_timeout: streams %0d, expected %0d", streams_done, target);
    end
    tick();
  endtask

  task automatic wait_emitted(input int target);
    int n;
    n = 0;
    while (emitted < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (emitted < target) begin
      n_checks++;
      $display("FAIL emit_timeout: emitted %0d, expected %0d", emitted, target);
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit1 [NN];
    int v;
    lit1 = '{1, 2, 3, 4, 2, 4, 6, 8, 3, 6, 9, 12, 4, 8, 12, 16};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Constant [1,2,3,4]: entry (i,j) = (i+1)*(j+1).
    send_batch(1, 2, 3, 4);
    idle(1);
    wait_streams(1);
    for (int k = 0; k < NN; k++) check("lit_1234", slog[0][k], lit1[k]);

    // Valid held high with changing data.
    for (int s = 0; s < S; s++)
      for (int k = 0; k < N; k++) begin
        v = int'($urandom_range(0, 300)) - 150;
        send_beat(16'(v));
      end
    idle(1);
    wait_streams(2);

    // Positive saturation.
    send_batch(32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF);
    idle(1);
    wait_streams(3);
    for (int k = 0; k < NN; k++) check("lit_sat_pos", slog[2][k], 32767);

    // Alternating +32767 / -32768 per stock.
    send_batch(32767, -32768, 32767, -32768);
    idle(1);
    wait_streams(4);
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        check("lit_sat_alt", slog[3][j*N + i], ((i % 2) == (j % 2)) ? 32767 : -32768);

    // Back-to-back batches: 5s then 0s.
    send_batch(5, 5, 5, 5);
    send_batch(0, 0, 0, 0);
    idle(1);
    wait_streams(6);
    for (int k = 0; k < NN; k++) check("lit_fives", slog[4][k], 25);
    for (int k = 0; k < NN; k++) check("lit_zeros", slog[5][k], 0);

    // Reset during ACCUM of the third sample, then during EMIT.
    send_vec(1, 2, 3, 4);
    send_vec(1, 2, 3, 4);
    send_vec(1, 2, 3, 4);
    idle(5);
    pulse_rst();
    idle(2);
    send_batch(3, 3, 3, 3);
    wait_emitted(7);
    pulse_rst();
    idle(2);
    send_batch(1, 1, 1, 1);
    idle(1);
    wait_streams(7);
    for (int k = 0; k < NN; k++) check("lit_ones_after_rst", slog[6][k], 1);

    // Diagonal-only samples: stock k nonzero only in samples k and k+4.
    for (int s = 0; s < S; s++)
      send_vec((s % N) == 0 ? 4 : 0, (s % N) == 1 ? 4 : 0,
               (s % N) == 2 ? 4 : 0, (s % N) == 3 ? 4 : 0);
    idle(1);
    wait_streams(8);
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        check("lit_diag", slog[7][j*N + i], (i == j) ? 4 : 0);

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
